// File: rtl/eth_send_arp.sv
// ARP reply generator: a matching ARP request becomes a preamble..FCS reply frame, one byte per transfer.
// Latency: the first preamble byte appears the cycle after the accepted i_req; the CRC runs over the 60 bytes from destination MAC onward.
// Backpressure: i_tx_rdy low freezes byte, state, counter and CRC; IFG timing ignores i_tx_rdy.
module eth_send_arp #(
   parameter int IFG_BYTES = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] i_local_mac,
   input  logic [31:0] i_local_ip,
   input  logic        i_req,
   input  logic [15:0] i_req_oper,
   input  logic [47:0] i_req_sha,
   input  logic [31:0] i_req_spa,
   input  logic [31:0] i_req_tpa,
   input  logic        i_tx_rdy,
   output logic [7:0]  o_data,
   output logic        o_data_vl,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_req_drop
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PREAMBLE = 3'd1;
   localparam logic [2:0] ETH_HDR  = 3'd2;
   localparam logic [2:0] ARP_BODY = 3'd3;
   localparam logic [2:0] PAD      = 3'd4;
   localparam logic [2:0] FCS      = 3'd5;
   localparam logic [2:0] IFG      = 3'd6;

   // The IDLE cycle that accepts the next request is the last idle slot, so IFG itself runs one cycle short.
   localparam logic [6:0] IFG_LAST = (IFG_BYTES > 1) ? 7'(IFG_BYTES - 2) : 7'd0;

   logic [2:0]   state;
   logic [2:0]   next_state;
   logic [6:0]   cnt;
   logic [6:0]   last_cnt;
   logic [47:0]  sha_q;
   logic [31:0]  spa_q;
   logic [31:0]  crc;
   logic         req_ok;
   logic         xfer;
   logic [111:0] hdr_vec;
   logic [223:0] arp_vec;
   logic [31:0]  fcs_vec;
   logic [6:0]   hdr_sel;
   logic [6:0]   arp_sel;

   function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   assign req_ok    = (i_req_oper == 16'h0001) && (i_req_tpa == i_local_ip);
   assign o_data_vl = state inside {PREAMBLE, ETH_HDR, ARP_BODY, PAD, FCS};
   assign o_busy    = (state != IDLE);
   assign xfer      = o_data_vl && i_tx_rdy;
   assign o_done    = xfer && (state == FCS) && (cnt == 7'd3);

   assign hdr_vec = {sha_q, i_local_mac, 16'h0806};
   assign arp_vec = {64'h0001_0800_0604_0002, i_local_mac, i_local_ip, sha_q, spa_q};
   assign fcs_vec = ~crc;
   assign hdr_sel = 7'd13 - cnt;
   assign arp_sel = 7'd27 - cnt;

   always_comb begin
      o_data     = 8'h00;
      last_cnt   = 7'd0;
      next_state = IDLE;
      case (state)
         PREAMBLE: begin
            o_data     = (cnt == 7'd7) ? 8'hD5 : 8'h55;
            last_cnt   = 7'd7;
            next_state = ETH_HDR;
         end
         ETH_HDR: begin
            o_data     = 8'(hdr_vec >> {hdr_sel, 3'b000});
            last_cnt   = 7'd13;
            next_state = ARP_BODY;
         end
         ARP_BODY: begin
            o_data     = 8'(arp_vec >> {arp_sel, 3'b000});
            last_cnt   = 7'd27;
            next_state = PAD;
         end
         PAD: begin
            last_cnt   = 7'd17;
            next_state = FCS;
         end
         FCS: begin
            o_data     = 8'(fcs_vec >> {cnt[1:0], 3'b000});
            last_cnt   = 7'd3;
            next_state = IFG;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sha_q      <= '0;
         spa_q      <= '0;
         crc        <= 32'hFFFF_FFFF;
         o_req_drop <= 1'b0;
      end else begin
         o_req_drop <= i_req && !((state == IDLE) && req_ok);
         case (state)
            PREAMBLE, ETH_HDR, ARP_BODY, PAD, FCS: begin
               if (xfer) begin
                  if (state inside {ETH_HDR, ARP_BODY, PAD}) begin
                     crc <= crc_next(crc, o_data);
                  end
                  if (cnt == last_cnt) begin
                     state <= next_state;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
            end
            IFG: begin
               if (cnt == IFG_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end
            default: begin
               crc <= 32'hFFFF_FFFF;
               cnt <= '0;
               if (i_req && req_ok) begin
                  sha_q <= i_req_sha;
                  spa_q <= i_req_spa;
                  state <= PREAMBLE;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_send_arp.sv
// Scoreboard bench for eth_send_arp: stimulus queues the expected reply bytes, a negedge monitor checks every transfer.
module tb_eth_send_arp;

   localparam int          IFG       = 12;
   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
   localparam logic [31:0] LOCAL_IP  = 32'hC0A8_000A;
   localparam logic [47:0] SHA_A     = 48'hAA_BB_CC_DD_EE_FF;
   localparam logic [31:0] SPA_A     = 32'hC0A8_0001;
   localparam logic [47:0] SHA_B     = 48'h01_23_45_67_89_AB;
   localparam logic [31:0] SPA_B     = 32'h0A00_0002;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [15:0] i_req_oper;
   logic [47:0] i_req_sha;
   logic [31:0] i_req_spa;
   logic [31:0] i_req_tpa;
   logic        i_tx_rdy;
   logic [7:0]  o_data;
   logic        o_data_vl;
   logic        o_busy;
   logic        o_done;
   logic        o_req_drop;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] frame [72];
   int         total = 0;
   int         bad = 0;
   int         xfer_cnt = 0;
   int         done_cnt = 0;
   int         drop_cnt = 0;
   int         idle_run = 0;
   int         last_gap = -1;
   bit         after_done = 1'b0;
   bit         rdy_rand = 1'b0;

   always #5 clk = ~clk;

   eth_send_arp #(.IFG_BYTES(IFG)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_local_mac(LOCAL_MAC),
      .i_local_ip (LOCAL_IP),
      .i_req      (i_req),
      .i_req_oper (i_req_oper),
      .i_req_sha  (i_req_sha),
      .i_req_spa  (i_req_spa),
      .i_req_tpa  (i_req_tpa),
      .i_tx_rdy   (i_tx_rdy),
      .o_data     (o_data),
      .o_data_vl  (o_data_vl),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_req_drop (o_req_drop)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: preamble, headers, ARP reply, pad, then a bit-serial CRC-32 over bytes 8..67.
   task automatic build_frame(input logic [47:0] sha, input logic [31:0] spa);
      logic [479:0] body;
      logic [31:0]  c;
      logic         fb;
      body = {sha, LOCAL_MAC, 16'h0806, 64'h0001_0800_0604_0002,
              LOCAL_MAC, LOCAL_IP, sha, spa, 144'h0};
      for (int i = 0; i < 7; i++) frame[i] = 8'h55;
      frame[7] = 8'hD5;
      for (int i = 0; i < 60; i++) frame[8 + i] = 8'(body >> (8 * (59 - i)));
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ frame[8 + i][j];
            c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
         end
      end
      c = ~c;
      for (int j = 0; j < 4; j++) frame[68 + j] = 8'(c >> (8 * j));
   endtask

   task automatic push_frame();
      for (int i = 0; i < 72; i++) sb_q.push_back({frame[i], 1'(i == 71)});
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_req(input logic [15:0] oper, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [31:0] tpa);
      i_req      = 1'b1;
      i_req_oper = oper;
      i_req_sha  = sha;
      i_req_spa  = spa;
      i_req_tpa  = tpa;
      step();
      i_req      = 1'b0;
   endtask

   task automatic wait_frame_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         step();
         if (sb_q.size() == 0 && !o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("frame_complete", 64'(ok), 64'd1);
   endtask

   task automatic wait_bytes(input int base, input int n);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (xfer_cnt - base >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk("reach_byte", 64'(ok), 64'd1);
   endtask

   initial begin
      i_tx_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         i_tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (o_data_vl && i_tx_rdy) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected no transfer", o_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("byte", 64'(o_data), 64'(mon_e.b));
            chk("done_flag", 64'(o_done), 64'(mon_e.last));
         end
         xfer_cnt++;
         if (after_done) begin
            last_gap   = idle_run;
            after_done = 1'b0;
         end
         if (o_done) after_done = 1'b1;
         idle_run = 0;
      end else begin
         if (o_done) begin
            total++;
            bad++;
            $display("FAIL stray_done: got 1 expected 0");
         end
         if (!o_data_vl) idle_run++;
      end
      if (o_req_drop) drop_cnt++;
      if (o_done) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xb, db, rb;
      rst        = 1'b1;
      i_req      = 1'b0;
      i_req_oper = '0;
      i_req_sha  = '0;
      i_req_spa  = '0;
      i_req_tpa  = '0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_data", 64'(o_data), 64'h00);
      chk("rst_vl", 64'(o_data_vl), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_drop", 64'(o_req_drop), 64'd0);
      step();

      // Full frame, sink always ready
      xb = xfer_cnt; db = done_cnt;
      build_frame(SHA_A, SPA_A);
      push_frame();
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      @(negedge clk);
      chk("latency_vl", 64'(o_data_vl), 64'd1);
      chk("latency_data", 64'(o_data), 64'h55);
      wait_frame_done(200);
      chk("frame_len", 64'(xfer_cnt - xb), 64'd72);
      chk("done_count", 64'(done_cnt - db), 64'd1);

      // Same frame with a stalling sink
      xb = xfer_cnt; db = done_cnt;
      rdy_rand = 1'b1;
      push_frame();
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      @(negedge clk);
      chk("stall_latency_vl", 64'(o_data_vl), 64'd1);
      wait_frame_done(600);
      rdy_rand = 1'b0;
      chk("stall_frame_len", 64'(xfer_cnt - xb), 64'd72);
      chk("stall_done_count", 64'(done_cnt - db), 64'd1);
      step();

      // Rejected requests: wrong target IP, then OPER=2
      xb = xfer_cnt; rb = drop_cnt;
      send_req(16'h0001, SHA_A, SPA_A, 32'hC0A8_0063);
      @(negedge clk);
      chk("drop_tpa", 64'(o_req_drop), 64'd1);
      chk("drop_tpa_busy", 64'(o_busy), 64'd0);
      @(negedge clk);
      chk("drop_tpa_end", 64'(o_req_drop), 64'd0);
      step();
      send_req(16'h0002, SHA_A, SPA_A, LOCAL_IP);
      @(negedge clk);
      chk("drop_oper", 64'(o_req_drop), 64'd1);
      chk("drop_oper_busy", 64'(o_busy), 64'd0);
      @(negedge clk);
      chk("drop_oper_end", 64'(o_busy), 64'd0);
      chk("drop_count", 64'(drop_cnt - rb), 64'd2);
      chk("drop_no_bytes", 64'(xfer_cnt - xb), 64'd0);
      step();

      // Second request during ARP_BODY
      xb = xfer_cnt; db = done_cnt; rb = drop_cnt;
      build_frame(SHA_B, SPA_B);
      push_frame();
      send_req(16'h0001, SHA_B, SPA_B, LOCAL_IP);
      wait_bytes(xb, 30);
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      @(negedge clk);
      chk("busy_drop", 64'(o_req_drop), 64'd1);
      chk("busy_drop_busy", 64'(o_busy), 64'd1);
      wait_frame_done(200);
      chk("busy_frame_len", 64'(xfer_cnt - xb), 64'd72);
      chk("busy_done_count", 64'(done_cnt - db), 64'd1);
      chk("busy_drop_count", 64'(drop_cnt - rb), 64'd1);

      // Reset mid-frame, then a clean frame
      xb = xfer_cnt; db = done_cnt;
      build_frame(SHA_A, SPA_A);
      push_frame();
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      wait_bytes(xb, 30);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("abort_vl", 64'(o_data_vl), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_len", 64'(xfer_cnt - xb), 64'd31);
      repeat (5) step();
      chk("abort_no_more", 64'(xfer_cnt - xb), 64'd31);
      chk("abort_no_done", 64'(done_cnt - db), 64'd0);
      xb = xfer_cnt;
      push_frame();
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      wait_frame_done(200);
      chk("post_rst_len", 64'(xfer_cnt - xb), 64'd72);

      // Back-to-back requests: the idle gap is exactly IFG cycles
      xb = xfer_cnt; db = done_cnt;
      build_frame(SHA_B, SPA_B);
      push_frame();
      send_req(16'h0001, SHA_B, SPA_B, LOCAL_IP);
      wait_frame_done(200);
      build_frame(SHA_A, SPA_A);
      push_frame();
      send_req(16'h0001, SHA_A, SPA_A, LOCAL_IP);
      wait_frame_done(200);
      chk("ifg_gap", 64'(last_gap), 64'(IFG));
      chk("b2b_len", 64'(xfer_cnt - xb), 64'd144);
      chk("b2b_done_count", 64'(done_cnt - db), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_send_arp.md
ETH_SEND_ARP -- requirements
Module: eth_send_arp

Interface
REQ-001 The block SHALL have parameter IFG_BYTES, default 12, meaning the number of idle byte slots enforced after each frame.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have the port i_local_mac, input, 48 bits: own MAC, static.
REQ-005 The block SHALL have the port i_local_ip, input, 32 bits: own IP, static.
REQ-006 The block SHALL have the port i_req, input, 1 bit: single-cycle pulse, a parsed ARP frame with good CRC is available.
REQ-007 The block SHALL have the port i_req_oper, input, 16 bits: ARP OPER of the received frame.
REQ-008 The block SHALL have the port i_req_sha, input, 48 bits: sender MAC of the received frame.
REQ-009 The block SHALL have the port i_req_spa, input, 32 bits: sender IP of the received frame.
REQ-010 The block SHALL have the port i_req_tpa, input, 32 bits: target IP of the received frame.
REQ-011 The block SHALL have the port i_tx_rdy, input, 1 bit: the MAC/PHY side accepts a byte this cycle.
REQ-012 The block SHALL have the port o_data, output, 8 bits: TX byte.
REQ-013 The block SHALL have the port o_data_vl, output, 1 bit: o_data is valid.
REQ-014 The block SHALL have the port o_busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have the port o_done, output, 1 bit: one-cycle pulse when the last FCS byte is accepted.
REQ-016 The block SHALL have the port o_req_drop, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-017 A byte SHALL transfer only on a cycle with o_data_vl=1 and i_tx_rdy=1; while i_tx_rdy=0, o_data, o_data_vl, state and counters SHALL hold.
REQ-018 State machine states: IDLE, PREAMBLE, ETH_HDR, ARP_BODY, PAD, FCS, IFG.
REQ-019 In IDLE, i_req=1 with i_req_oper=16'h0001 and i_req_tpa=i_local_ip SHALL latch i_req_sha and i_req_spa and go to PREAMBLE on the next cycle.
REQ-020 In IDLE, an i_req that fails the REQ-019 check SHALL pulse o_req_drop the next cycle and stay in IDLE.
REQ-021 An i_req arriving in any non-IDLE state SHALL pulse o_req_drop and SHALL NOT disturb the frame in progress.
REQ-022 PREAMBLE SHALL transfer 7 bytes of 8'h55 followed by 8'hD5, then go to ETH_HDR.
REQ-023 ETH_HDR SHALL transfer 14 bytes: latched SHA (6 bytes, MSB first), i_local_mac (6), then 8'h08, 8'h06.
REQ-024 ARP_BODY SHALL transfer 28 bytes: 00 01 08 00 06 04 00 02, then i_local_mac (6), i_local_ip (4), latched SHA (6), latched SPA (4), all MSB first.
REQ-025 PAD SHALL transfer 18 bytes of 8'h00, giving 60 bytes from the destination MAC onward.
REQ-026 The CRC-32 SHALL be computed over exactly those 60 bytes using the reflected polynomial 0xEDB88320 and initial value 32'hFFFFFFFF, and the result SHALL be complemented.
REQ-027 The CRC register SHALL update only on transferred bytes.
REQ-028 FCS SHALL transfer the complemented CRC in 4 bytes, bits [7:0] first; o_done SHALL pulse on acceptance of the 4th byte, and the block SHALL then enter IFG.
REQ-029 A full frame SHALL be exactly 72 transferred bytes.
REQ-030 IFG SHALL hold o_data_vl=0 for IFG_BYTES clk cycles, independent of i_tx_rdy, then return to IDLE.
REQ-031 An i_req on the first IDLE cycle after IFG SHALL be accepted.
REQ-032 A single byte counter, 7 bits wide, SHALL index the bytes within each state and SHALL clear on every state change; it SHALL never wrap within a state.
REQ-033 o_data_vl SHALL be 1 in PREAMBLE through FCS and 0 in IDLE and IFG.
REQ-034 Latency: the first 8'h55 SHALL be presented on the cycle after the accepting i_req, with o_data_vl=1.

Reset
REQ-035 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter and latched fields.
REQ-036 Reset values: o_data=8'h00, o_data_vl=0, o_busy=0, o_done=0, o_req_drop=0, CRC register 32'hFFFFFFFF.
REQ-037 Reset mid-frame SHALL abort the frame immediately, with no FCS and no IFG; o_data_vl SHALL be 0 on the cycle after the rst edge.

Verification
REQ-038 Bench SHALL cover: local MAC 02:00:00:00:00:01, local IP 192.168.0.10; i_req with OPER=1, TPA=C0A8000A, SHA=AA:BB:CC:DD:EE:FF, SPA=C0A80001; i_tx_rdy=1 -> 72 bytes, o_done at byte 72, destination MAC AABBCCDDEEFF, FCS matching a software CRC-32.
REQ-039 Bench SHALL cover: as REQ-038 with i_tx_rdy randomly toggled at 50% -> byte stream identical to REQ-038 and no duplicated or skipped bytes.
REQ-040 Bench SHALL cover: i_req with TPA=C0A80063, or with OPER=2 -> o_req_drop pulses once, o_busy stays 0.
REQ-041 Bench SHALL cover: second i_req during ARP_BODY -> o_req_drop pulse, first frame unchanged.
REQ-042 Bench SHALL cover: rst asserted at byte 30 -> o_data_vl=0 on the next cycle; a subsequent request yields a correct full frame.
REQ-043 Bench SHALL cover: back-to-back requests -> exactly IFG_BYTES (12) cycles with o_data_vl=0 between the last FCS byte and the next 8'h55.
